dmem_responder: RTL and testbench
=================================

# dmem_responder

Word-organised data-memory responder that serves load/store requests issued by the pipeline's MEM stage over a valid/ready request channel and a valid/ready response channel. It is the memory-side end of the CPU data port. It adds the following on top of a bare RAM:
- configurable wait states;
- byte-enable writes;
- alignment and range checking;
- a post-reset clear sweep that zeroes every word.

## Interface
- `DEPTH_LOG2`, default 12: log2 of the number of 32-bit words (default 4096 words, byte range 0x0000–0x3FFF).
- `LATENCY`, default 2: wait-state cycles inserted between request accept and memory access (0–15).
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; bit i selects `req_wdata[8i+7:8i]`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester accepts response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned or out of range.
- `clr_done`  out  1  clear sweep finished.

## Operation
- State machine has four states: CLEAR, IDLE, WAIT, RESP.
- **CLEAR** (entered on reset):
  - a word counter starts at 0 and writes 0 to one word per cycle.
  - After writing word 2^DEPTH_LOG2−1, go to IDLE and set `clr_done`=1.
  - `clr_done` stays 1 until the next reset.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, capture we, addr, wdata and be, load the wait counter with LATENCY, and go to WAIT.
- **WAIT:**
  - If counter≠0, decrement it.
  - If counter==0, perform the access and go to RESP on the same edge.
- **Access:**
  - off = addr − BASE_ADDR, computed in 32-bit unsigned arithmetic with wrap.
  - err = (addr[1:0]≠0) || (off ≥ 4·2^DEPTH_LOG2).
  - Word index = off[DEPTH_LOG2+1:2].
  - If err: no memory change, `rsp_rdata`=0, `rsp_err`=1.
  - Load: `rsp_rdata` = mem[index], `rsp_err`=0.
  - Store: each byte with be[i]=1 is written; `rsp_rdata`=0, `rsp_err`=0. be=4'b0000 is a legal no-op store.
- **RESP:**
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable until `rsp_valid`&&`rsp_ready`.
  - On that handshake go to IDLE and clear `rsp_valid`, `rsp_rdata` and `rsp_err`.
- Only one request is outstanding at a time. `req_ready`=0 in CLEAR, WAIT and RESP.
- Request inputs are ignored outside the IDLE accept cycle, so changes after accept have no effect.

## Timing
- Reset values, applied asynchronously on `reset`=1: state=CLEAR, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `clr_done`=0, clear counter=0, wait counter=0.
- Reset mid-operation abandons any pending request or response with no memory write and restarts the CLEAR sweep.
- Clear takes 2^DEPTH_LOG2 cycles after reset deasserts. `req_ready` rises on the edge that writes the last word.
- Accept at edge E0 → `rsp_valid` high after edge E0+LATENCY+1.
- If `rsp_ready` is 1 throughout, `rsp_valid` lasts 1 cycle and `req_ready` returns after the next edge.
- Minimum request spacing is LATENCY+3 cycles.
- A load following a store to the same word returns the updated data, because the store commits at its WAIT→RESP edge.
- `rsp_valid` high with `rsp_ready` low: outputs are held indefinitely with no timeout.
- `req_valid` asserted in CLEAR: not accepted; the request is accepted on the first IDLE cycle if `req_valid` is still high.

## Test plan
Bench configuration: DEPTH_LOG2=4, LATENCY=2, BASE_ADDR=0x0.

1. Release reset → `req_ready`=0 for exactly 16 cycles, then `req_ready`=1 and `clr_done`=1. Load every word 0x00–0x3C → rdata=0, err=0.
2. Store 0xDEADBEEF at 0x8 with be=4'hF, then load 0x8 → rdata=0xDEADBEEF. Accept-to-`rsp_valid` latency is 3 edges.
3. Store 0x11223344 at 0x8 with be=4'b0101, then load 0x8 → rdata=0xDE22BE44.
4. Load 0x6 (misaligned) → err=1, rdata=0. Store to 0x40 (out of range) → err=1 and memory unchanged. Store with be=0 → err=0 and memory unchanged.
5. Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, rdata and err stable for all 5 cycles. Toggling req_* during this window has no effect, and `req_ready`=0 throughout.
6. Assert `reset` while in WAIT of a store to 0x4 → outputs drop to reset values immediately. Word 0x4 is 0 after the sweep, and the clear sweep reruns in full.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data-memory end of the CPU data port.
// Serves one load/store at a time over valid/ready request/response
// channels, with LATENCY wait states, byte-enable stores, alignment and
// range checks, and a zeroing sweep of every word after reset.
// Ports:
//   clk, reset           clock, async active-high reset
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_addr, req_wdata  byte address, store data
//   req_be               byte enables for req_wdata
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   load data (0 for stores/errors), error flag
//   clr_done             clear sweep finished
module dmem_responder #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        clr_done
);

   localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
   localparam logic [32:0] SPAN = 33'(WORDS) << 2;
   localparam logic [DEPTH_LOG2-1:0] CNT_ONE = 1;
   localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DEPTH_LOG2-1:0] clr_cnt;
   logic [3:0]            wait_cnt;

   logic        cap_we;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_be;

   logic [31:0] mem [WORDS];

   logic [31:0]           off;
   logic                  acc_err;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic                  accept;
   logic                  access;
   logic                  clr_last;

   // Offset wraps in 32 bits, so addresses below BASE_ADDR land far
   // above the window and are reported as out of range.
   assign off      = cap_addr - BASE_ADDR;
   assign acc_err  = (cap_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
   assign acc_idx  = off[DEPTH_LOG2+1:2];
   assign clr_last = (clr_cnt == CNT_LAST);
   assign accept   = (state == IDLE) && req_valid;
   assign access   = (state == WAIT) && (wait_cnt == 4'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         CLEAR: begin
            if (clr_last) state_nxt = IDLE;
         end
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = WAIT;
         end
         WAIT: begin
            if (wait_cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clr_cnt   <= '0;
         wait_cnt  <= 4'd0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_be    <= 4'd0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         clr_done  <= 1'b0;
      end else begin
         if (state == CLEAR) begin
            clr_cnt <= clr_cnt + CNT_ONE;
            if (clr_last) clr_done <= 1'b1;
         end
         if (accept) begin
            wait_cnt  <= 4'(LATENCY);
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
         end
         if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (access) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || cap_we) ? '0 : mem[acc_idx];
         end
         if ((state == RESP) && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end
      end
   end

   // Storage has no reset; the sweep zeroes it instead. Writes are
   // suppressed while reset is held so an abandoned store never lands.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
         end else if (access && cap_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
               if (cap_be[i]) mem[acc_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder
// against a word-array reference model (DEPTH_LOG2=4, LATENCY=2).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        clr_done;

   int tests = 0;
   int fails = 0;

   logic [31:0] mdl [16];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_LOG2(4),
      .LATENCY(2),
      .BASE_ADDR(32'h0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_be(req_be),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .clr_done(clr_done)
   );

   task automatic cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory of 16 words at byte 0x00..0x3F.
   function automatic void ref_access(input logic we,
                                      input logic [31:0] addr,
                                      input logic [31:0] wdata,
                                      input logic [3:0] be,
                                      output logic [31:0] rd,
                                      output logic err);
      int unsigned w;
      err = (addr % 4 != 0) || (addr >= 32'd64);
      rd  = 32'h0;
      w   = addr / 4;
      if (!err) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mdl[w][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            rd = mdl[w];
         end
      end
   endfunction

   task automatic scramble;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
   endtask

   task automatic xfer(input string tag, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold);
      logic [31:0] erd;
      logic        eerr;
      int          n;
      ref_access(we, addr, wdata, be, erd, eerr);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_valid = 1'b1;
      rsp_ready = (hold == 0);
      n = 0;
      while (!req_ready && n < 200) begin
         cycle;
         n++;
      end
      chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
      cycle;
      req_valid = 1'b0;
      scramble;
      n = 0;
      while (!rsp_valid && n < 50) begin
         cycle;
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'd3);
      chk({tag, " rdata"}, rsp_rdata, erd);
      chk({tag, " err"}, 32'(rsp_err), 32'(eerr));
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'($urandom);
         scramble;
         cycle;
         chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, " hold rdata"}, rsp_rdata, erd);
         chk({tag, " hold err"}, 32'(rsp_err), 32'(eerr));
         chk({tag, " hold ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      cycle;
      chk({tag, " post valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, " post ready"}, 32'(req_ready), 32'd1);
      chk({tag, " post rdata"}, rsp_rdata, 32'd0);
      chk({tag, " post err"}, 32'(rsp_err), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
      chk({tag, " clr_done"}, 32'(clr_done), 32'd0);
   endtask

   task automatic sweep(input string tag);
      int n;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (!req_ready && n < 100) begin
         cycle;
         n++;
      end
      chk({tag, " sweep cycles"}, 32'(n), 32'd16);
      chk({tag, " clr_done"}, 32'(clr_done), 32'd1);
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 16; i++) mdl[i] = $urandom;

      repeat (3) cycle;
      check_reset_outputs("reset");
      sweep("init");
      for (int i = 0; i < 16; i++) xfer("clr load", 1'b0, 32'(i * 4), 32'h0, 4'h0, 0);

      xfer("st full", 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0);
      xfer("ld full", 1'b0, 32'h8, 32'h0, 4'h0, 0);
      chk("ld full model", mdl[2], 32'hDEAD_BEEF);

      xfer("st be5", 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 0);
      xfer("ld be5", 1'b0, 32'h8, 32'h0, 4'h0, 0);
      chk("ld be5 model", mdl[2], 32'hDE22_BE44);

      xfer("ld misal", 1'b0, 32'h6, 32'h0, 4'h0, 0);
      xfer("st oor", 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0);
      xfer("ld w0", 1'b0, 32'h0, 32'h0, 4'h0, 0);
      xfer("st be0", 1'b1, 32'h8, 32'h5555_5555, 4'h0, 0);
      xfer("ld be0", 1'b0, 32'h8, 32'h0, 4'h0, 0);

      xfer("ld hold", 1'b0, 32'h8, 32'h0, 4'h0, 5);
      xfer("st hold", 1'b1, 32'h9, 32'h0, 4'hF, 5);
      xfer("ld after hold", 1'b0, 32'h8, 32'h0, 4'h0, 0);

      for (int t = 0; t < 60; t++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) a = $urandom;
         else if (r == 1) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else a = 32'($urandom_range(0, 15) * 4);
         xfer("rand", 1'($urandom), a, $urandom, 4'($urandom), 0);
      end
      for (int i = 0; i < 16; i++) xfer("rand rd", 1'b0, 32'(i * 4), 32'h0, 4'h0, 0);

      xfer("st w1", 1'b1, 32'h4, 32'h1234_5678, 4'hF, 0);
      xfer("ld w1", 1'b0, 32'h4, 32'h0, 4'h0, 0);
      req_we    = 1'b1;
      req_addr  = 32'h4;
      req_wdata = 32'hCAFE_F00D;
      req_be    = 4'hF;
      req_valid = 1'b1;
      cycle;
      req_valid = 1'b0;
      cycle;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid reset");
      cycle;
      cycle;
      sweep("rerun");
      for (int i = 0; i < 16; i++) xfer("post rst load", 1'b0, 32'(i * 4), 32'h0, 4'h0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
